// File: rtl/spi_link_pkg.sv
// Shared word width, timing defaults and TX state encoding for the SPI link controller.
package spi_link_pkg;

  localparam int KEY_LENGTH_DEF   = 32;
  localparam int SEND_HOLD_DEF    = 3;
  localparam int FRAME_CYCLES_DEF = 600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spi_link_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr_i with wrap.
// Zero latency; no backpressure, the caller decides when to consume the pick.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    any_o  = 1'b0;
    pick_o = '0;
    idx_o  = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/spi_link_ctrl.sv
// Arbitrates requesters onto the SPI slave TX path (grant 1 cycle after request, frame = SEND_HOLD+FRAME_CYCLES+1 cycles)
// and captures RX words into a valid/ready register 3 cycles after ready rises; a word arriving while unconsumed is dropped and flagged.
module spi_link_ctrl
  import spi_link_pkg::*;
#(
  parameter int KEY_LENGTH   = KEY_LENGTH_DEF,
  parameter int NUM_REQ      = 4,
  parameter int SEND_HOLD    = SEND_HOLD_DEF,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*KEY_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic [KEY_LENGTH-1:0]         spi_data_to_send,
  output logic                          spi_send,
  input  logic [KEY_LENGTH-1:0]         spi_data_received,
  input  logic                          spi_data_received_ready,
  output logic [KEY_LENGTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overflow,
  input  logic                          rx_overflow_clr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(SEND_HOLD + 1);
  localparam int FW = $clog2(FRAME_CYCLES + 1);

  tx_state_e             state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         gidx_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic                  busy_q;
  logic [KEY_LENGTH-1:0] data_q;
  logic                  send_q;
  logic [HW-1:0]         hold_q;
  logic [FW-1:0]         wait_q;

  logic               arb_any;
  logic [NUM_REQ-1:0] arb_pick;
  logic [IW-1:0]      arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .any_o  (arb_any),
    .pick_o (arb_pick),
    .idx_o  (arb_idx)
  );

  // The slave has no busy flag, so the frame is timed blind: hold send, then wait out the worst-case frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      send_q  <= 1'b0;
      hold_q  <= '0;
      wait_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q   <= arb_pick;
            gidx_q  <= arb_idx;
            busy_q  <= 1'b1;
            data_q  <= req_data[arb_idx*KEY_LENGTH +: KEY_LENGTH];
            send_q  <= 1'b1;
            hold_q  <= HW'(1);
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (hold_q == HW'(SEND_HOLD)) begin
            send_q  <= 1'b0;
            wait_q  <= FW'(1);
            state_q <= ST_WAIT;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_q == FW'(FRAME_CYCLES)) begin
            done_q  <= gnt_q;
            state_q <= ST_DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign busy             = busy_q;
  assign spi_data_to_send = data_q;
  assign spi_send         = send_q;

  logic                  sync1_q, sync2_q, sync3_q;
  logic                  cap_pulse;
  logic [KEY_LENGTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_ovf_q;

  assign cap_pulse = sync2_q & ~sync3_q;

  // Data bus is taken unsynchronized: the slave holds it a full SCLK period past ready, outlasting the sync delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      sync1_q <= spi_data_received_ready;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (cap_pulse) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= spi_data_received;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (cap_pulse && rx_valid_q && !rx_ready) begin
        rx_ovf_q <= 1'b1;
      end else if (rx_overflow_clr) begin
        rx_ovf_q <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overflow = rx_ovf_q;

endmodule

// File: doc/spi_link_ctrl.md
Name: spi_link_ctrl

Overview:
- Clock-domain-side controller for the custom 3-wire SPI slave.
- Round-robin arbitrates NUM_REQ on-chip requesters (auth engine, key manager, debug) for the slave's transmit path.
- Drives a clean send pulse, holds the outgoing word, and times out each frame, because the slave exposes no busy flag.
- Also synchronizes the slave's receive-ready strobe and presents received words through a valid/ready port with overflow detection.

Parameters:
- KEY_LENGTH, 32, word width carried per SPI frame.
- NUM_REQ, 4, number of transmit requesters (≥2).
- SEND_HOLD, 3, clk cycles spi_send is held high (≥2; the slave double-registers send before edge-detecting).
- FRAME_CYCLES, 600, clk cycles waited after send drop before the path counts as free (≥ (KEY_LENGTH+2) SCLK periods in clk cycles).

Ports:
- clk  in  1  system clock; only clock in the block
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester transmit request, level, held until done
- req_data  in  NUM_REQ*KEY_LENGTH  requester i word at bits [i*KEY_LENGTH +: KEY_LENGTH]
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high from grant until done inclusive
- spi_data_to_send  out  KEY_LENGTH  word to slave dataToSend
- spi_send  out  1  to slave send
- spi_data_received  in  KEY_LENGTH  from slave dataReceived (SCLK domain, quasi-static)
- spi_data_received_ready  in  1  from slave dataReceived_ready (SCLK domain)
- rx_data  out  KEY_LENGTH  captured received word
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_overflow  out  1  sticky; a word was dropped
- rx_overflow_clr  in  1  clears rx_overflow

Behaviour:
- Reset: all of the following are 0: outputs, state, counters and synchronizers. The state is IDLE and the round-robin pointer is 0, so index 0 has highest priority.
- TX FSM states and transitions:
  - IDLE: if any req is high in cycle t, select the first set req scanning from ptr upward, with wrap.
  - Cycle t+1, registered: gnt[k]=1, busy=1, spi_data_to_send latched from req_data slice k, spi_send=1. Go to SEND.
  - SEND: hold spi_send=1 for SEND_HOLD cycles total, then drop it and go to WAIT.
  - WAIT: count FRAME_CYCLES cycles, then go to DONE.
  - DONE: one cycle with done[k]=1. gnt and busy clear on the next edge. ptr is set to (k+1) mod NUM_REQ. Go to IDLE.
- spi_data_to_send is stable from grant through DONE. A requester changing req_data after grant has no effect.
- Dropping req after grant does not abort: the frame completes and done still pulses.
- The DONE→IDLE cycle is always an IDLE cycle. A request seen in it is granted on the following edge, giving a minimum 1-cycle gap between frames.
- Only one grant at a time; gnt is never non-one-hot.
- Reset mid-frame returns to IDLE with spi_send=0 on the next edge. Recovery of the slave's own state is out of scope.
- RX path:
  - 2-flop synchronizer on spi_data_received_ready, plus a third flop for rising-edge detect, giving cap_pulse.
  - On cap_pulse: if !rx_valid, or rx_valid && rx_ready in the same cycle, load rx_data from spi_data_received and set rx_valid=1.
  - On cap_pulse with rx_valid && !rx_ready: keep the old rx_data and set rx_overflow=1.
  - rx_valid && rx_ready with no cap_pulse clears rx_valid.
  - rx_overflow_clr clears the flag. If it coincides with a new overflow, the set wins.
  - Capture latency: 3 clk cycles from the synchronous-visible ready edge to rx_valid.
  - spi_data_received is sampled unsynchronized. Legality comes from the slave holding data for one full SCLK period after ready rises, with clk ≥ 4× SCLK.
- Counter widths: $clog2(SEND_HOLD+1) and $clog2(FRAME_CYCLES+1). No wrap is possible within a state.

Decomposition:
- Shared package spi_link_pkg holds:
  - KEY_LENGTH default
  - the FSM state encoding (IDLE, SEND, WAIT, DONE)
  - the SEND_HOLD and FRAME_CYCLES defaults
- One sub-module, rr_arbiter (NUM_REQ), which takes req and ptr and returns a one-hot pick plus its index.
- The synchronizer and RX handshake stay inline.

Test Plan:
- Single req[2] with data 0xA5A5_1234 → gnt=0100 and spi_send high for exactly 3 cycles, spi_data_to_send=0xA5A5_1234, done[2] pulses once after 3+600 cycles, then ptr=3.
- req=1111 held continuously → grants in order 0,1,2,3,0 with each done before the next gnt and a 1-cycle IDLE gap between frames.
- req[1] dropped two cycles after grant → frame still completes and done[1] pulses; req_data changed mid-frame leaves spi_data_to_send unchanged.
- rst asserted during WAIT → next edge shows spi_send=0, gnt=0, busy=0, state IDLE; a request then pending is granted normally.
- Two ready strobes carrying 0x0000_00FF and 0xDEAD_BEEF with rx_ready=0 → rx_data stays 0x0000_00FF and rx_overflow=1; assert rx_ready → rx_valid drops; rx_overflow_clr → flag clears.
- Ready strobe coinciding with rx_valid && rx_ready → new word loads, rx_valid stays 1, no overflow.
